// File: rtl/ddr_cas_scheduler.sv
// DDR4 CAS scheduler: spaces READ/WRITE CAS commands, counts CAS latency
// and tracks outstanding data bursts until the burst block reports done.
module ddr_cas_scheduler #(
  parameter int TCCD            = 4,
  parameter int TWTR            = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int DLY_W           = 6
) (
  input  logic             clock_t,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [1:0]       req_rw,
  output logic             req_ready,
  input  logic [DLY_W-1:0] rd_delay,
  input  logic [DLY_W-1:0] wr_delay,
  input  logic [3:0]       burst_len,
  output logic             cas_cmd,
  output logic [1:0]       cas_rw,
  output logic             data_start,
  output logic [1:0]       data_rw,
  input  logic             data_done,
  output logic [2:0]       outstanding,
  output logic             err_sticky
);

  localparam logic [1:0] RW_RD = 2'b01;
  localparam logic [1:0] RW_WR = 2'b10;
  localparam int         MAXO  = MAX_OUTSTANDING;
  localparam logic [2:0] MAX_O = 3'(MAX_OUTSTANDING);
  localparam int         CW    = 8;
  localparam logic [CW-1:0] GAP_LD  = CW'(TCCD - 1);
  localparam logic [CW-1:0] TWTR_LD = CW'(TWTR);

  logic [DLY_W-1:0] q_cnt   [MAXO];
  logic [DLY_W-1:0] q_cnt_n [MAXO];
  logic [1:0]       q_rw    [MAXO];
  logic [1:0]       q_rw_n  [MAXO];
  logic [2:0]       q_num;
  logic [2:0]       q_num_n;

  logic [1:0]       d_rw    [MAXO];
  logic [1:0]       d_rw_n  [MAXO];
  logic [2:0]       out_n;

  logic [CW-1:0]    gap_cnt;
  logic [CW-1:0]    gap_n;
  logic [CW-1:0]    twtr_cnt;
  logic [CW-1:0]    twtr_n;

  logic             is_rd;
  logic             is_wr;
  logic             legal;
  logic [DLY_W-1:0] raw_dly;
  logic [DLY_W-1:0] eff_dly;
  logic [3:0]       half;
  logic [DLY_W-1:0] young;
  logic             order_ok;
  logic             accept;
  logic             done_ok;
  logic             head_pop;

  assign is_rd   = (req_rw == RW_RD);
  assign is_wr   = (req_rw == RW_WR);
  assign legal   = is_rd | is_wr;
  assign raw_dly = is_rd ? rd_delay : wr_delay;
  assign eff_dly = (raw_dly == '0) ? DLY_W'(1) : raw_dly;
  assign half    = burst_len >> 1;

  always_comb begin
    young = '0;
    for (int i = 0; i < MAXO; i++) begin
      if (3'(i + 1) == q_num) young = q_cnt[i];
    end
  end

  // New burst must land after the youngest one has left the data bus.
  assign order_ok = (q_num == 3'd0) ||
    ({1'b0, eff_dly} >= ({1'b0, young} + (DLY_W+1)'(half)));

  assign req_ready = !reset
    && (outstanding < MAX_O)
    && (gap_cnt == '0)
    && legal
    && (!is_rd || (twtr_cnt == '0))
    && order_ok;

  assign accept   = req_valid && req_ready;
  assign done_ok  = data_done && (outstanding != 3'd0);
  assign head_pop = (q_num != 3'd0) && (q_cnt[0] <= DLY_W'(1));

  always_comb begin
    q_cnt_n = q_cnt;
    q_rw_n  = q_rw;
    q_num_n = q_num;
    for (int i = 0; i < MAXO; i++) begin
      if ((3'(i) < q_num) && (q_cnt[i] != '0))
        q_cnt_n[i] = q_cnt[i] - DLY_W'(1);
    end
    if (head_pop) begin
      for (int i = 0; i < MAXO - 1; i++) begin
        q_cnt_n[i] = q_cnt_n[i+1];
        q_rw_n[i]  = q_rw_n[i+1];
      end
      q_cnt_n[MAXO-1] = '0;
      q_rw_n[MAXO-1]  = '0;
      q_num_n = q_num - 3'd1;
    end
    if (accept) begin
      for (int i = 0; i < MAXO; i++) begin
        if (3'(i) == q_num_n) begin
          q_cnt_n[i] = eff_dly;
          q_rw_n[i]  = req_rw;
        end
      end
      q_num_n = q_num_n + 3'd1;
    end
  end

  // Done-order FIFO: burst types in issue order, popped by data_done.
  always_comb begin
    d_rw_n = d_rw;
    out_n  = outstanding;
    if (done_ok) begin
      for (int i = 0; i < MAXO - 1; i++) begin
        d_rw_n[i] = d_rw_n[i+1];
      end
      d_rw_n[MAXO-1] = '0;
      out_n = outstanding - 3'd1;
    end
    if (accept) begin
      for (int i = 0; i < MAXO; i++) begin
        if (3'(i) == out_n) d_rw_n[i] = req_rw;
      end
      out_n = out_n + 3'd1;
    end
  end

  always_comb begin
    gap_n = gap_cnt;
    if (accept)
      gap_n = GAP_LD;
    else if (gap_cnt != '0)
      gap_n = gap_cnt - CW'(1);
  end

  always_comb begin
    twtr_n = twtr_cnt;
    if (done_ok && (d_rw[0] == RW_WR))
      twtr_n = TWTR_LD;
    else if (twtr_cnt != '0)
      twtr_n = twtr_cnt - CW'(1);
  end

  always_ff @(posedge clock_t or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAXO; i++) begin
        q_cnt[i] <= '0;
        q_rw[i]  <= '0;
        d_rw[i]  <= '0;
      end
      q_num       <= '0;
      outstanding <= '0;
      gap_cnt     <= '0;
      twtr_cnt    <= '0;
      cas_cmd     <= 1'b0;
      cas_rw      <= 2'b00;
      data_start  <= 1'b0;
      data_rw     <= 2'b00;
      err_sticky  <= 1'b0;
    end else begin
      q_cnt       <= q_cnt_n;
      q_rw        <= q_rw_n;
      q_num       <= q_num_n;
      d_rw        <= d_rw_n;
      outstanding <= out_n;
      gap_cnt     <= gap_n;
      twtr_cnt    <= twtr_n;
      cas_cmd     <= accept;
      cas_rw      <= accept ? req_rw : 2'b00;
      data_start  <= head_pop;
      data_rw     <= head_pop ? q_rw[0] : 2'b00;
      if (data_done && (outstanding == 3'd0))
        err_sticky <= 1'b1;
    end
  end

endmodule
